// File: rtl/s_cntr_pkg.sv
// Shared constants for the s_cntr ripple-carry event counter.
package s_cntr_pkg;

  // Default counter width; 4 bits is the normative configuration.
  localparam int unsigned CNTR_WIDTH = 4;

  // Level of the reset input that clears the counter.
  localparam logic RST_ACTIVE = 1'b0;

endpackage : s_cntr_pkg

// File: rtl/s_cntr_cell.sv
// One bit-slice of the ripple counter: a T flip-flop with asynchronous
// active-low clear, plus the AND/MUX stage that forwards the carry.
module s_cntr_cell
  import s_cntr_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic carry_i,
  output logic q_o,
  output logic carry_o
);

  logic q_q;
  logic q_d;

  // Toggle this bit when the carry reaches it; otherwise hold.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output on
    // every path, so no latch is inferred.
    q_d = q_q ^ carry_i;
  end

  // State register, cleared asynchronously while reset is held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking '<=' so every slice samples the
    // pre-edge carry chain together.
    if (rst_ni == RST_ACTIVE) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

  // Carry passes on only when this bit is already 1 (it is about to wrap).
  assign carry_o = q_q ? carry_i : 1'b0;

endmodule : s_cntr_cell

// File: rtl/s_cntr.sv
// Synchronous up-counter of qualified input events, built as a chain of
// s_cntr_cell slices with a combinational ripple carry. Output is taken
// straight from the slice flip-flops, so it is glitch-free.
module s_cntr
  import s_cntr_pkg::*;
#(
  parameter int unsigned WIDTH = CNTR_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_out
);

  // carry[k] enters slice k; carry[WIDTH] falls off the top on wrap-around.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] q;
  logic             unused_carry;

  // The enable gates the event request to form the chain's carry-in.
  assign carry[0] = i_en & i_in;

  for (genvar k = 0; k < WIDTH; k++) begin : g_cell
    s_cntr_cell u_cell (
      .clk_i   (i_clk),
      .rst_ni  (i_rst),
      .carry_i (carry[k]),
      .q_o     (q[k]),
      .carry_o (carry[k+1])
    );
  end

  // The counter wraps silently; there is no overflow flag.
  assign unused_carry = carry[WIDTH];

  assign o_out = q;

endmodule : s_cntr

// File: tb/tb_s_cntr.sv
// Directed bench for s_cntr: reset, counting, async clear mid-count,
// wrap-around, gating by enable/input, alternating input, reset at an edge.
module tb_s_cntr;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic         inp = 1'b0;
  logic [W-1:0] out;

  int n_cmp = 0;
  int n_err = 0;

  s_cntr #(.WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_in  (inp),
    .i_en  (en),
    .o_out (out)
  );

  // 100 MHz bench clock; rising edges at 5, 15, 25, ... ns.
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 ns so sampling and driving stay
  // away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clear the counter between edges and release it again before the next edge.
  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    en  = 1'b1;
    inp = 1'b1;
    #1;
    n_cmp++;
    if (out !== 4'd0) begin
      n_err++;
      $display("FAIL reset_initial: got %0d expected 0", out);
    end
    // Hold reset ~100 ns with inc high; edges must be ignored.
    for (int i = 0; i < 10; i++) tick();
    n_cmp++;
    if (out !== 4'd0) begin
      n_err++;
      $display("FAIL reset_hold: got %0d expected 0", out);
    end
    rst = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_cmp++;
      if (out !== 4'(k)) begin
        n_err++;
        $display("FAIL count_step%0d: got %0d expected %0d", k, out, k);
      end
    end
  endtask

  task automatic test_async_clear();
    en  = 1'b0;
    inp = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    // Still well before the next rising edge.
    n_cmp++;
    if (out !== 4'd0) begin
      n_err++;
      $display("FAIL async_clear: got %0d expected 0", out);
    end
    en  = 1'b1;
    inp = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    n_cmp++;
    if (out !== 4'd0) begin
      n_err++;
      $display("FAIL async_hold200: got %0d expected 0", out);
    end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    n_cmp++;
    if (out !== 4'd10) begin
      n_err++;
      $display("FAIL recount_ten: got %0d expected 10", out);
    end
  endtask

  task automatic test_wrap();
    pulse_reset();
    en  = 1'b1;
    inp = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      n_cmp++;
      if (out !== 4'(k % 16)) begin
        n_err++;
        $display("FAIL wrap_step%0d: got %0d expected %0d", k, out, k % 16);
      end
    end
  endtask

  task automatic test_gating();
    pulse_reset();
    en  = 1'b1;
    inp = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if (out !== 4'd3) begin
      n_err++;
      $display("FAIL gate_preload: got %0d expected 3", out);
    end
    en  = 1'b0;
    inp = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (out !== 4'd3) begin
        n_err++;
        $display("FAIL gate_en_low%0d: got %0d expected 3", i, out);
      end
    end
    en  = 1'b1;
    inp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (out !== 4'd3) begin
        n_err++;
        $display("FAIL gate_in_low%0d: got %0d expected 3", i, out);
      end
    end
  endtask

  task automatic test_alternate();
    int exp_cnt;
    pulse_reset();
    exp_cnt = 0;
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      inp = (i % 2 == 0) ? 1'b1 : 1'b0;
      tick();
      if (i % 2 == 0) exp_cnt++;
      n_cmp++;
      if (out !== 4'(exp_cnt)) begin
        n_err++;
        $display("FAIL alt_step%0d: got %0d expected %0d", i, out, exp_cnt);
      end
    end
  endtask

  task automatic test_reset_at_edge();
    pulse_reset();
    en  = 1'b1;
    inp = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    n_cmp++;
    if (out !== 4'd7) begin
      n_err++;
      $display("FAIL edge_preload: got %0d expected 7", out);
    end
    // Reset lands on the same edge as a qualified count.
    @(posedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (out !== 4'd0) begin
      n_err++;
      $display("FAIL edge_reset: got %0d expected 0", out);
    end
    tick();
    n_cmp++;
    if (out !== 4'd0) begin
      n_err++;
      $display("FAIL edge_reset_hold: got %0d expected 0", out);
    end
    en  = 1'b0;
    rst = 1'b1;
    tick();
    n_cmp++;
    if (out !== 4'd0) begin
      n_err++;
      $display("FAIL edge_release_idle: got %0d expected 0", out);
    end
    en = 1'b1;
    tick();
    n_cmp++;
    if (out !== 4'd1) begin
      n_err++;
      $display("FAIL edge_first_count: got %0d expected 1", out);
    end
  endtask

  initial begin
    test_reset();
    test_async_clear();
    test_wrap();
    test_gating();
    test_alternate();
    test_reset_at_edge();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_s_cntr

// File: doc/s_cntr.md
# s_cntr

Synchronous 4-bit up-counter with a ripple-carry (MUX-chain) structure, used in the ADPLL datapath to accumulate qualified input events per clock. Each rising clock edge with both enable and input high advances the count by one. An asynchronous active-low reset clears the count. The output is fully registered so downstream phase/frequency logic sees a glitch-free value.

## Interface
- `WIDTH`, default 4: counter width in bits. The 4-bit configuration is the normative one.
- `i_clk`, input, 1: system clock; all state changes on the rising edge.
- `i_rst`, input, 1: reset.
  - Asynchronous and active-low.
  - `i_rst = 0` clears the counter immediately, with no clock edge needed.
  - `i_rst = 1` means normal operation.
- `i_in`, input, 1: count request; a count is requested when high at a clock edge.
- `i_en`, input, 1: count enable; gates `i_in`.
- `o_out`, output, `WIDTH`: current count, unsigned binary, registered.

## Operation
- Count qualifier: `inc = i_en & i_in`, sampled at the rising edge of `i_clk`.
- `inc = 1`: `o_out <= o_out + 1`, modulo `2^WIDTH`.
- `inc = 0`: `o_out` holds its value.
- Wrap-around: 15 plus one increment gives 0. No saturation and no overflow flag.
- `i_en = 0` suppresses counting whatever the value of `i_in`. `i_in = 0` also suppresses counting whatever the value of `i_en`.
- Reset:
  - While `i_rst = 0`, `o_out = 0` and increments are ignored.
  - Asserting `i_rst` mid-count clears `o_out` asynchronously and loses the partial count.
- Reset release:
  - Reset must be released synchronously to `i_clk` by the integrating logic.
  - The first edge after release may count if `inc = 1`.
- Carry logic:
  - Bit k toggles when `inc` is high and bits 0..k-1 are all 1.
  - The carry is formed as a ripple chain: `c0 = inc`, `c(k+1) = ck & q(k)`.
  - The chain is purely combinational between registers and must settle within one clock period. Target: 200 MHz, 5 ns period.
- No internal state other than the `WIDTH` count flip-flops.

## Timing
- Reset value: `o_out = 0`, reached asynchronously on `i_rst` falling, independent of the clock.
- Latency:
  - `inc` sampled at edge N is reflected on `o_out` after edge N.
  - One register stage; no combinational path from inputs to `o_out`.
- After M consecutive edges with `inc = 1`, starting from 0, `o_out = M mod 16`.
- Inputs change away from the rising edge (setup and hold with respect to `i_clk`). Behaviour for inputs changing exactly at the edge is not defined.
- Reset and a clock edge arriving together: reset wins and `o_out = 0`.
- Clock frequency: 200 MHz nominal. The carry ripple across `WIDTH` stages plus the register setup time must fit within 5 ns.

## Structure
- A shared package holds:
  - the `WIDTH` default (4);
  - the reset-active level constant (0).
- Sub-module `s_cntr_cell`:
  - one bit-slice, containing a T-type flip-flop with asynchronous active-low clear and a carry-out AND/MUX;
  - inputs: clock, reset, carry-in; outputs: `q`, carry-out.
  - `s_cntr` instantiates `WIDTH` cells in a generate loop and chains the carries.
- Top level: combines `i_en & i_in` into the chain carry-in and concatenates the cell outputs onto `o_out`.

## Test plan
- Hold `i_rst = 0` for 100 ns, then release with `i_en = 1`, `i_in = 1` for 10 rising edges → `o_out = 10`, incrementing by exactly 1 per edge (1, 2, …, 10).
- From count 10, assert `i_rst = 0` between clock edges with `i_en = 0`, `i_in = 0` → `o_out = 0` immediately, before the next edge, and it stays 0 for 200 ns. Release, then apply 10 enabled edges → `o_out = 10` again.
- `i_en = 1`, `i_in = 1` for 17 edges from reset → `o_out` passes 15, wraps to 0, and ends at 1.
- `i_en = 0`, `i_in = 1` for 5 edges, then `i_en = 1`, `i_in = 0` for 5 edges, starting at count 3 → `o_out` remains 3 throughout.
- Alternate `i_in` high and low each edge with `i_en = 1` for 8 edges from 0 → `o_out = 4`.
- Assert `i_rst` while `o_out = 7` and `inc = 1` coincides with a clock edge → `o_out = 0` and no increment is applied after release until the next qualified edge.
